// File: rtl/bf16_mult_pipe.sv
// Three-stage BF16 multiplier with a single global advance enable.
// Subnormals flush to zero, rounding is truncation, and NaN results use the canonical 7FC0.
module bf16_mult_pipe #(
    parameter int DATA_TYPE = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_TYPE-1:0] A,
    input  logic [DATA_TYPE-1:0] B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_TYPE-1:0] O
);

    logic              en;
    logic              v1, v2, v3;

    logic              a_nan, a_inf, a_zero;
    logic              b_nan, b_inf, b_zero;
    logic              in_nan, in_inf, in_zero;

    logic              s1_sign, s1_nan, s1_inf, s1_zero;
    logic [7:0]        s1_ea, s1_eb, s1_ma, s1_mb;

    logic              s2_sign, s2_nan, s2_inf, s2_zero;
    logic [15:0]       s2_prod;
    logic signed [9:0] s2_exp;

    logic signed [9:0] norm_exp;
    logic [6:0]        norm_man;
    logic [15:0]       packed_result;

    assign en        = out_ready | ~v3;
    assign in_ready  = en;
    assign out_valid = v3;

    // Operand classification; inf*0 is folded into NaN so the zero flag never hides it.
    always_comb begin
        a_nan   = (A[14:7] == 8'hFF) && (A[6:0] != 7'h00);
        a_inf   = (A[14:7] == 8'hFF) && (A[6:0] == 7'h00);
        a_zero  = (A[14:7] == 8'h00);
        b_nan   = (B[14:7] == 8'hFF) && (B[6:0] != 7'h00);
        b_inf   = (B[14:7] == 8'hFF) && (B[6:0] == 7'h00);
        b_zero  = (B[14:7] == 8'h00);
        in_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        in_inf  = (a_inf | b_inf) & ~in_nan;
        in_zero = (a_zero | b_zero) & ~in_nan;
    end

    always_comb begin
        norm_man = s2_prod[13:7];
        norm_exp = s2_exp;
        if (s2_prod[15]) begin
            norm_man = s2_prod[14:8];
            norm_exp = s2_exp + 10'sd1;
        end
    end

    // Special-case flags take priority over the normalised arithmetic result.
    always_comb begin
        packed_result = {s2_sign, norm_exp[7:0], norm_man};
        if (s2_nan) begin
            packed_result = 16'h7FC0;
        end else if (s2_inf) begin
            packed_result = {s2_sign, 8'hFF, 7'h00};
        end else if (s2_zero) begin
            packed_result = {s2_sign, 15'h0000};
        end else if (norm_exp >= 10'sd255) begin
            packed_result = {s2_sign, 8'hFF, 7'h00};
        end else if (norm_exp <= 10'sd0) begin
            packed_result = {s2_sign, 15'h0000};
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
            s1_ea   <= 8'h00;
            s1_eb   <= 8'h00;
            s1_ma   <= 8'h00;
            s1_mb   <= 8'h00;
            s2_sign <= 1'b0;
            s2_nan  <= 1'b0;
            s2_inf  <= 1'b0;
            s2_zero <= 1'b0;
            s2_prod <= 16'h0000;
            s2_exp  <= 10'sd0;
            O       <= 16'h0000;
        end else if (en) begin
            v1      <= in_valid;
            s1_sign <= A[15] ^ B[15];
            s1_nan  <= in_nan;
            s1_inf  <= in_inf;
            s1_zero <= in_zero;
            s1_ea   <= A[14:7];
            s1_eb   <= B[14:7];
            s1_ma   <= a_zero ? 8'h00 : {1'b1, A[6:0]};
            s1_mb   <= b_zero ? 8'h00 : {1'b1, B[6:0]};

            v2      <= v1;
            s2_sign <= s1_sign;
            s2_nan  <= s1_nan;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_prod <= s1_ma * s1_mb;
            s2_exp  <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - 10'sd127;

            v3      <= v2;
            if (v2) begin
                O <= packed_result;
            end
        end
    end

endmodule

// File: tb/tb_bf16_mult_pipe.sv
// Directed-vector bench for bf16_mult_pipe: streaming, bubbles, stall and reset corners.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_bf16_mult_pipe;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expected;
    } vec_t;

    logic        CLK;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] O;

    int   total;
    int   bad;
    vec_t vecs[10];

    bf16_mult_pipe #(.DATA_TYPE(16)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [15:0] a, input logic [15:0] b);
        in_valid = valid;
        A        = a;
        B        = b;
    endtask

    // Streams the first n vectors, optionally on alternate cycles, and checks
    // that each product appears exactly 3 cycles after it was presented.
    task automatic run_stream(input int n, input bit gaps, input string tag);
        int   sent[64];
        int   vi;
        int   k;
        int   cycles;
        logic exp_v;
        vi     = 0;
        cycles = (gaps ? 2 * n : n) + 4;
        for (int t = 0; t < cycles; t++) begin
            @(negedge CLK);
            if (t >= 1) begin
                k     = t - 3;
                exp_v = (k >= 0) && (sent[k] >= 0);
                check_output({tag, "_valid"}, {15'h0, out_valid}, {15'h0, exp_v});
                if (exp_v) begin
                    check_output({tag, "_O"}, O, vecs[sent[k]].expected);
                end
            end
            check_output({tag, "_in_ready"}, {15'h0, in_ready}, 16'h0001);
            if (vi < n && (!gaps || (t % 2 == 0))) begin
                apply_stimulus(1'b1, vecs[vi].a, vecs[vi].b);
                sent[t] = vi;
                vi++;
            end else begin
                apply_stimulus(1'b0, 16'h0000, 16'h0000);
                sent[t] = -1;
            end
        end
        apply_stimulus(1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{16'h4040, 16'h3F80, 16'h4040};
        vecs[1] = '{16'h3FA0, 16'h4020, 16'h4048};
        vecs[2] = '{16'h4100, 16'h4480, 16'h4600};
        vecs[3] = '{16'hC040, 16'h3F80, 16'hC040};
        vecs[4] = '{16'h7F00, 16'h4000, 16'h7F80};
        vecs[5] = '{16'h7F80, 16'h0000, 16'h7FC0};
        vecs[6] = '{16'h7FC1, 16'h3F80, 16'h7FC0};
        vecs[7] = '{16'h0001, 16'h4000, 16'h0000};
        vecs[8] = '{16'h8000, 16'h4040, 16'h8000};
        vecs[9] = '{16'h0080, 16'h0080, 16'h0000};

        rst       = 1'b0;
        out_ready = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 16'h0000);
        #3;
        check_output("reset_valid", {15'h0, out_valid}, 16'h0000);
        check_output("reset_O", O, 16'h0000);
        check_output("reset_in_ready", {15'h0, in_ready}, 16'h0001);
        repeat (2) @(negedge CLK);
        rst = 1'b1;

        $display("[TB] back-to-back stream of all vectors");
        run_stream(10, 1'b0, "stream");

        $display("[TB] bubble stream");
        run_stream(4, 1'b1, "bubble");

        $display("[TB] stall");
        repeat (3) @(negedge CLK);
        apply_stimulus(1'b1, vecs[0].a, vecs[0].b);
        @(negedge CLK);
        apply_stimulus(1'b1, vecs[1].a, vecs[1].b);
        @(negedge CLK);
        apply_stimulus(1'b1, vecs[2].a, vecs[2].b);
        @(negedge CLK);
        check_output("stall_first_valid", {15'h0, out_valid}, 16'h0001);
        check_output("stall_first_O", O, vecs[0].expected);
        apply_stimulus(1'b0, 16'h0000, 16'h0000);
        out_ready = 1'b0;
        #1;
        check_output("stall_in_ready_drop", {15'h0, in_ready}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_output("stall_hold_valid", {15'h0, out_valid}, 16'h0001);
            check_output("stall_hold_O", O, vecs[0].expected);
            check_output("stall_hold_in_ready", {15'h0, in_ready}, 16'h0000);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        check_output("stall_rel1_valid", {15'h0, out_valid}, 16'h0001);
        check_output("stall_rel1_O", O, vecs[1].expected);
        @(negedge CLK);
        check_output("stall_rel2_valid", {15'h0, out_valid}, 16'h0001);
        check_output("stall_rel2_O", O, vecs[2].expected);
        @(negedge CLK);
        check_output("stall_drained", {15'h0, out_valid}, 16'h0000);

        $display("[TB] reset mid-stream");
        apply_stimulus(1'b1, vecs[4].a, vecs[4].b);
        @(negedge CLK);
        apply_stimulus(1'b1, vecs[5].a, vecs[5].b);
        @(negedge CLK);
        apply_stimulus(1'b1, vecs[6].a, vecs[6].b);
        @(negedge CLK);
        check_output("prereset_valid", {15'h0, out_valid}, 16'h0001);
        apply_stimulus(1'b0, 16'h0000, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        check_output("midreset_valid", {15'h0, out_valid}, 16'h0000);
        check_output("midreset_O", O, 16'h0000);
        check_output("midreset_in_ready", {15'h0, in_ready}, 16'h0001);
        repeat (2) @(negedge CLK);
        check_output("inreset_valid", {15'h0, out_valid}, 16'h0000);
        rst = 1'b1;
        apply_stimulus(1'b1, vecs[3].a, vecs[3].b);
        @(negedge CLK);
        apply_stimulus(1'b0, 16'h0000, 16'h0000);
        check_output("postreset_c1_valid", {15'h0, out_valid}, 16'h0000);
        @(negedge CLK);
        check_output("postreset_c2_valid", {15'h0, out_valid}, 16'h0000);
        @(negedge CLK);
        check_output("postreset_c3_valid", {15'h0, out_valid}, 16'h0001);
        check_output("postreset_c3_O", O, vecs[3].expected);
        @(negedge CLK);
        check_output("postreset_no_stale", {15'h0, out_valid}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
